reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of registers in the target register file.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST_n  input  1  asynchronous reset, active low.
REQ-006 Start  input  1  dump request pulse, sampled only in IDLE.
REQ-007 Abort  input  1  cancel an in-progress dump.
REQ-008 StartReg  input  ADDR_W  first register to read.
REQ-009 Count  input  ADDR_W+1  words to dump; 0 means REG_COUNT.
REQ-010 RdAddr  output  ADDR_W  read address to the register-file read port.
REQ-011 RdData  input  32  combinational read data for RdAddr.
REQ-012 OutValid  output  1  OutData/OutIndex/OutLast valid.
REQ-013 OutReady  input  1  consumer accepts the beat.
REQ-014 OutData  output  32  captured register word.
REQ-015 OutIndex  output  ADDR_W  register number of OutData.
REQ-016 OutLast  output  1  final beat of the dump.
REQ-017 Busy  output  1  dump in progress.
REQ-018 Done  output  1  one-cycle completion pulse.
REQ-019 Checksum  output  32  XOR of all transferred words (see Configuration).

Function
REQ-020 SHALL implement FSM states IDLE, LOAD and SEND.
- IDLE -> LOAD on Start.
- LOAD -> SEND after one cycle.
- SEND -> LOAD on a non-last transfer.
- SEND -> IDLE on the last transfer or on Abort.
- LOAD -> IDLE on Abort.
REQ-021 On Start in IDLE, SHALL latch ptr=StartReg and remaining=(Count==0 ? REG_COUNT : Count), and assert Busy from the next cycle.
REQ-022 RdAddr SHALL equal ptr at all times; in IDLE, ptr holds its last value.
REQ-023 In LOAD, SHALL register OutData=RdData, OutIndex=ptr and OutLast=(remaining==1), and raise OutValid on entry to SEND; Start at cycle N gives OutValid at N+2.
REQ-024 A transfer SHALL occur when OutValid and OutReady are both 1; until then OutData, OutIndex and OutLast SHALL hold stable and OutValid SHALL NOT drop, except on Abort or reset.
REQ-025 On each transfer, SHALL set ptr=(ptr+1) mod REG_COUNT (wrap 31 -> 0) and decrement remaining.
REQ-026 Each word SHALL be a snapshot taken at its LOAD edge; later register-file writes SHALL NOT alter a held OutData.
REQ-027 Throughput SHALL be one word per two cycles with OutReady held at 1.
REQ-028 Done SHALL pulse for exactly one cycle after the last transfer, when Busy returns to 0; Done SHALL NOT pulse on Abort.
REQ-029 Start while Busy SHALL be ignored; Start and Abort together in IDLE SHALL be ignored.
REQ-030 Abort in LOAD or SEND SHALL return the block to IDLE on the next edge with OutValid=0 and Busy=0; the beat presented in that same cycle SHALL NOT count as transferred.
REQ-031 Register 0 SHALL be dumped as read from RdData, with no special-casing.

Reset
REQ-032 RST_n low SHALL asynchronously force state=IDLE and ptr=0, and drive OutValid=0, OutData=0, OutIndex=0, OutLast=0, Busy=0, Done=0 and Checksum=0.
REQ-033 Reset mid-dump SHALL discard the dump with no Done pulse.

Configuration
REQ-034 With DUMP_CHECKSUM_EN defined:
- Checksum SHALL clear on an accepted Start.
- Checksum SHALL XOR in OutData on each transfer.
- Checksum SHALL hold its final value from the Done cycle until the next Start.
REQ-035 Without DUMP_CHECKSUM_EN, Checksum SHALL be constant 0 and no accumulator logic SHALL exist.

Verification
REQ-036 Register file preloaded with reg[i]=i*0x11111111, StartReg=0, Count=0, OutReady=1 -> 32 beats of indices 0..31 with matching data, OutLast only on index 31, one Done pulse.
REQ-037 StartReg=30, Count=4 -> indices 30,31,0,1, with OutLast on index 1.
REQ-038 OutReady held 0 for 5 cycles during a beat and register written meanwhile -> OutData unchanged, OutValid stays 1, and the beat is accepted when OutReady=1.
REQ-039 Abort during beat 3 of 8 -> OutValid=0 and Busy=0 next cycle, no Done; Start issued while Busy -> ignored.
REQ-040 RST_n pulsed low mid-dump -> all outputs 0 immediately; a following Start runs a clean dump.
REQ-041 DUMP_CHECKSUM_EN defined, words 0x1, 0x2, 0x4 dumped -> Checksum=0x7 at Done; macro undefined -> Checksum=0.

Source files
------------

// File: rtl/reg_dump_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_reader_if
//  Function : Control, register-file read port and output stream bundle of
//             the register dump reader.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_dump_reader_if #(
    parameter int ADDR_W = 5
);
    logic              Start;
    logic              Abort;
    logic [ADDR_W-1:0] StartReg;
    logic [ADDR_W:0]   Count;
    logic [ADDR_W-1:0] RdAddr;
    logic [31:0]       RdData;
    logic              OutValid;
    logic              OutReady;
    logic [31:0]       OutData;
    logic [ADDR_W-1:0] OutIndex;
    logic              OutLast;
    logic              Busy;
    logic              Done;
    logic [31:0]       Checksum;

    modport master (
        output Start, Abort, StartReg, Count, RdData, OutReady,
        input  RdAddr, OutValid, OutData, OutIndex, OutLast, Busy, Done, Checksum
    );

    modport slave (
        input  Start, Abort, StartReg, Count, RdData, OutReady,
        output RdAddr, OutValid, OutData, OutIndex, OutLast, Busy, Done, Checksum
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_reader
//  Function : Streams a window of a register file out as valid/ready beats,
//             one snapshot word per two cycles. Optional XOR checksum of the
//             transferred words is enabled by defining DUMP_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_reader #(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5
) (
    input  wire logic         CLK,
    input  wire logic         RST_n,
    reg_dump_reader_if.slave  bus
);

    localparam logic [1:0]        c_IDLE     = 2'd0;
    localparam logic [1:0]        c_LOAD     = 2'd1;
    localparam logic [1:0]        c_SEND     = 2'd2;
    localparam logic [ADDR_W-1:0] c_LAST_REG = ADDR_W'(REG_COUNT - 1);
    localparam logic [ADDR_W:0]   c_FULL     = (ADDR_W + 1)'(REG_COUNT);

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic [31:0]       r_outData;
    logic [ADDR_W-1:0] r_outIndex;
    logic              r_outLast;
    logic              r_done;
    logic              w_startOk;
    logic              w_xfer;
    logic              w_outValid;
    logic              w_busy;

    assign w_startOk = (r_state == c_IDLE) && bus.Start && !bus.Abort;
    // Abort outranks a simultaneous handshake: that beat is not consumed.
    assign w_xfer    = (r_state == c_SEND) && bus.OutReady && !bus.Abort;

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: if (w_startOk) w_nextState = c_LOAD;
            c_LOAD: w_nextState = bus.Abort ? c_IDLE : c_SEND;
            c_SEND: begin
                if (bus.Abort) begin
                    w_nextState = c_IDLE;
                end else if (w_xfer) begin
                    w_nextState = r_outLast ? c_IDLE : c_LOAD;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_outValid = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            c_LOAD: w_busy = 1'b1;
            c_SEND: begin
                w_busy     = 1'b1;
                w_outValid = 1'b1;
            end
            default: begin
                w_busy     = 1'b0;
                w_outValid = 1'b0;
            end
        endcase
    end

    // Pointer, beat capture and completion pulse
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_outData   <= '0;
            r_outIndex  <= '0;
            r_outLast   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_startOk) begin
                r_ptr       <= bus.StartReg;
                r_remaining <= (bus.Count == '0) ? c_FULL : bus.Count;
            end
            if (r_state == c_LOAD) begin
                r_outData  <= bus.RdData;
                r_outIndex <= r_ptr;
                r_outLast  <= (r_remaining == (ADDR_W + 1)'(1));
            end
            if (w_xfer) begin
                r_ptr       <= (r_ptr == c_LAST_REG) ? '0 : r_ptr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
                r_done      <= r_outLast;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_checksum <= '0;
        end else if (w_startOk) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ r_outData;
        end
    end

    assign bus.Checksum = r_checksum;
`else
    assign bus.Checksum = 32'd0;
`endif

    assign bus.RdAddr   = r_ptr;
    assign bus.OutValid = w_outValid;
    assign bus.OutData  = r_outData;
    assign bus.OutIndex = r_outIndex;
    assign bus.OutLast  = r_outLast;
    assign bus.Busy     = w_busy;
    assign bus.Done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_reader
//  Function : Directed self-checking bench for reg_dump_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_dump_reader;

`ifdef DUMP_CHECKSUM_EN
    localparam bit c_CK_EN = 1'b1;
`else
    localparam bit c_CK_EN = 1'b0;
`endif

    logic        CLK;
    logic        RST_n;
    logic [31:0] regFile [32];
    int          nCompared;
    int          nMismatched;

    reg_dump_reader_if #(.ADDR_W(5)) bus ();

    reg_dump_reader #(.REG_COUNT(32), .ADDR_W(5)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    assign bus.RdData = regFile[bus.RdAddr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues a Start and follows the dump to Done with OutReady held high.
    task automatic runDump(input int sReg, input int cnt, input int nExp);
        int          idx;
        int          nBeats;
        int          nDone;
        int          doneCyc;
        logic [31:0] xr;
        logic [31:0] ckSeen;
        bus.StartReg = 5'(sReg);
        bus.Count    = 6'(cnt);
        bus.Start    = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("busyAfterStart", 32'(bus.Busy), 32'd1);
        idx     = sReg;
        nBeats  = 0;
        nDone   = 0;
        doneCyc = -1;
        xr      = 32'd0;
        ckSeen  = 32'd0;
        for (int cyc = 0; cyc < 300 && nDone == 0; cyc++) begin
            if (bus.Done) begin
                nDone   = 1;
                doneCyc = cyc;
                ckSeen  = bus.Checksum;
                check("busyAtDone", 32'(bus.Busy), 32'd0);
                check("checksumAtDone", bus.Checksum, c_CK_EN ? xr : 32'd0);
            end else begin
                if (bus.OutValid && bus.OutReady) begin
                    check("beatIndex", 32'(bus.OutIndex), 32'(idx));
                    check("beatData", bus.OutData, regFile[idx[4:0]]);
                    check("beatLast", 32'(bus.OutLast), 32'(nBeats == nExp - 1));
                    xr     = xr ^ regFile[idx[4:0]];
                    nBeats = nBeats + 1;
                    idx    = (idx + 1) % 32;
                end
                tick();
            end
        end
        check("doneSeen", 32'(nDone), 32'd1);
        check("beatCount", 32'(nBeats), 32'(nExp));
        check("cyclesToDone", 32'(doneCyc), 32'(2 * nExp));
        tick();
        check("donePulseWidth", 32'(bus.Done), 32'd0);
        check("checksumHold", bus.Checksum, ckSeen);
    endtask

    initial begin
        nCompared     = 0;
        nMismatched   = 0;
        RST_n         = 1'b0;
        bus.Start     = 1'b0;
        bus.Abort     = 1'b0;
        bus.StartReg  = 5'd0;
        bus.Count     = 6'd0;
        bus.OutReady  = 1'b1;
        for (int i = 0; i < 32; i++) regFile[i] = 32'(i) * 32'h1111_1111;

        // Reset state
        tick();
        tick();
        check("rstOutValid", 32'(bus.OutValid), 32'd0);
        check("rstBusy", 32'(bus.Busy), 32'd0);
        check("rstDone", 32'(bus.Done), 32'd0);
        check("rstOutData", bus.OutData, 32'd0);
        check("rstRdAddr", 32'(bus.RdAddr), 32'd0);
        check("rstChecksum", bus.Checksum, 32'd0);
        RST_n = 1'b1;
        tick();

        // Full dump, Count=0 means all 32 registers
        runDump(0, 0, 32);

        // Wrapping window 30,31,0,1
        runDump(30, 4, 4);

        // Back-pressure with a register write while the beat is held
        bus.StartReg = 5'd5;
        bus.Count    = 6'd2;
        bus.OutReady = 1'b0;
        bus.Start    = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("bpLoadValid", 32'(bus.OutValid), 32'd0);
        tick();
        check("bpFirstValid", 32'(bus.OutValid), 32'd1);
        check("bpFirstData", bus.OutData, 32'h5555_5555);
        regFile[5] = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bpHoldValid", 32'(bus.OutValid), 32'd1);
            check("bpHoldData", bus.OutData, 32'h5555_5555);
            check("bpHoldIndex", 32'(bus.OutIndex), 32'd5);
        end
        bus.OutReady = 1'b1;
        tick();
        check("bpAcceptedValid", 32'(bus.OutValid), 32'd0);
        check("bpPtrAdvanced", 32'(bus.RdAddr), 32'd6);
        tick();
        check("bpSecondIndex", 32'(bus.OutIndex), 32'd6);
        check("bpSecondLast", 32'(bus.OutLast), 32'd1);
        tick();
        check("bpDone", 32'(bus.Done), 32'd1);
        regFile[5] = 32'h5555_5555;
        tick();

        // Start+Abort together in IDLE is ignored
        bus.StartReg = 5'd0;
        bus.Count    = 6'd8;
        bus.Start    = 1'b1;
        bus.Abort    = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        check("startAbortIgnored", 32'(bus.Busy), 32'd0);

        // Abort during beat 3 of 8; Start while busy ignored
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        check("abBeat0", 32'(bus.OutIndex), 32'd0);
        bus.Start    = 1'b1;
        bus.StartReg = 5'd20;
        tick();
        bus.Start = 1'b0;
        tick();
        check("busyStartIgnored", 32'(bus.OutIndex), 32'd1);
        tick();
        tick();
        check("abBeat2Valid", 32'(bus.OutValid), 32'd1);
        check("abBeat2Index", 32'(bus.OutIndex), 32'd2);
        bus.Abort = 1'b1;
        tick();
        bus.Abort = 1'b0;
        check("abortValid", 32'(bus.OutValid), 32'd0);
        check("abortBusy", 32'(bus.Busy), 32'd0);
        check("abortNoDone", 32'(bus.Done), 32'd0);
        tick();
        check("abortNoDoneLater", 32'(bus.Done), 32'd0);
        check("abortPtrHeld", 32'(bus.RdAddr), 32'd2);

        // Reset pulse mid-dump, then a clean dump of 1,2,4
        bus.StartReg = 5'd3;
        bus.Count    = 6'd5;
        bus.Start    = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        check("preRstValid", 32'(bus.OutValid), 32'd1);
        #2;
        RST_n = 1'b0;
        #1;
        check("midRstValid", 32'(bus.OutValid), 32'd0);
        check("midRstBusy", 32'(bus.Busy), 32'd0);
        check("midRstData", bus.OutData, 32'd0);
        check("midRstIndex", 32'(bus.OutIndex), 32'd0);
        check("midRstRdAddr", 32'(bus.RdAddr), 32'd0);
        check("midRstChecksum", bus.Checksum, 32'd0);
        tick();
        RST_n = 1'b1;
        tick();
        check("postRstDone", 32'(bus.Done), 32'd0);
        regFile[0] = 32'h1;
        regFile[1] = 32'h2;
        regFile[2] = 32'h4;
        runDump(0, 3, 3);
        check("finalChecksum", bus.Checksum, c_CK_EN ? 32'h7 : 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
